fib_checker: RTL and testbench

FIB_CHECKER -- requirements
Module: fib_checker

---
 rtl/fib_pkg.sv | 20 ++
 rtl/fib_checker.sv | 173 +++++++++++++++++
 tb/tb_fib_checker.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// -----------------------------------------------------------------------------
// fib_pkg
// Shared definitions for the Fibonacci sequence generator and checker:
//   - fib_state_t    : checker state encoding
//   - FIB_WIDTH_DEF  : default data width of a sequence term
//   - FIB_CNT_W_DEF  : default width of the consecutive-match counter
// -----------------------------------------------------------------------------
package fib_pkg;

    localparam int FIB_WIDTH_DEF = 4;
    localparam int FIB_CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        S_SEED0 = 2'd0,  // waiting for the first seed term
        S_SEED1 = 2'd1,  // waiting for the second seed term
        S_TRACK = 2'd2,  // predicting and comparing every accepted term
        S_FAULT = 2'd3   // sequence broken; only clr or rst leave this state
    } fib_state_t;

endpackage : fib_pkg

// File: rtl/fib_checker.sv
// -----------------------------------------------------------------------------
// fib_checker
// Watches a stream of terms and checks that it follows the Fibonacci rule
// t[n] = t[n-1] + t[n-2] (mod 2^WIDTH). The first two accepted terms seed the
// predictor; every later term is compared against the prediction.
//
// Parameters
//   WIDTH      : term width (default from fib_pkg)
//   CNT_W      : width of the saturating consecutive-match counter
//   CHECK_SEED : 1 = the seeds must be exactly 0 then 1
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   in_valid  in   in_data carries a term this cycle
//   in_data   in   observed term
//   clr       in   synchronous restart to seed capture (beats in_valid)
//   match     out  one-cycle pulse, last accepted term equalled prediction
//   mismatch  out  one-cycle pulse, last accepted term broke the sequence
//   locked    out  high while tracking
//   expected  out  predicted next term while tracking, 0 otherwise
//   term_cnt  out  consecutive matches since the last seed or fault
//
// Build option
//   FIB_CHECKER_RESYNC_EN : when defined, a tracking mismatch re-seeds from the
//   offending term (it becomes the first seed) instead of entering S_FAULT.
// -----------------------------------------------------------------------------
module fib_checker
    import fib_pkg::*;
#(
    parameter int WIDTH      = FIB_WIDTH_DEF,
    parameter int CNT_W      = FIB_CNT_W_DEF,
    parameter bit CHECK_SEED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clr,
    output logic             match,
    output logic             mismatch,
    output logic             locked,
    output logic [WIDTH-1:0] expected,
    output logic [CNT_W-1:0] term_cnt
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    fib_state_t       r_state;
    logic [WIDTH-1:0] r_a;          // older of the two previous terms
    logic [WIDTH-1:0] r_b;          // newer of the two previous terms
    logic [CNT_W-1:0] r_term_cnt;
    logic             r_match;
    logic             r_mismatch;

    fib_state_t       w_state_next;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;
    logic [CNT_W-1:0] w_term_cnt_next;
    logic             w_match_next;
    logic             w_mismatch_next;

    // Prediction; the sum truncates to WIDTH bits, giving the modular wrap.
    logic [WIDTH-1:0] w_sum;
    logic             w_cnt_full;

    assign w_sum      = r_a + r_b;
    assign w_cnt_full = (r_term_cnt == {CNT_W{1'b1}});

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_SEED0;
            r_a        <= '0;
            r_b        <= '0;
            r_term_cnt <= '0;
            r_match    <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_a        <= w_a_next;
            r_b        <= w_b_next;
            r_term_cnt <= w_term_cnt_next;
            r_match    <= w_match_next;
            r_mismatch <= w_mismatch_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // Idle cycles hold everything and drop both pulses.
        w_state_next    = r_state;
        w_a_next        = r_a;
        w_b_next        = r_b;
        w_term_cnt_next = r_term_cnt;
        w_match_next    = 1'b0;
        w_mismatch_next = 1'b0;

        if (clr) begin
            // Restart wins; any term presented this cycle is dropped.
            w_state_next    = S_SEED0;
            w_a_next        = '0;
            w_b_next        = '0;
            w_term_cnt_next = '0;
        end else if (in_valid) begin
            unique case (r_state)
                S_SEED0: begin
                    if (CHECK_SEED && (in_data != '0)) begin
                        w_mismatch_next = 1'b1;
                    end else begin
                        w_a_next     = in_data;
                        w_state_next = S_SEED1;
                    end
                end

                S_SEED1: begin
                    if (CHECK_SEED && (in_data != WIDTH'(1))) begin
                        // A bad second seed invalidates the first one too.
                        w_mismatch_next = 1'b1;
                        w_state_next    = S_SEED0;
                    end else begin
                        w_b_next     = in_data;
                        w_state_next = S_TRACK;
                    end
                end

                S_TRACK: begin
                    if (in_data == w_sum) begin
                        w_a_next     = r_b;
                        w_b_next     = in_data;
                        w_match_next = 1'b1;
                        if (!w_cnt_full) begin
                            w_term_cnt_next = r_term_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_mismatch_next = 1'b1;
                        w_term_cnt_next = '0;
`ifdef FIB_CHECKER_RESYNC_EN
                        // Treat the offending term as a fresh first seed.
                        w_a_next     = in_data;
                        w_state_next = S_SEED1;
`else
                        w_state_next = S_FAULT;
`endif
                    end
                end

                S_FAULT: begin
                    // Terms are ignored until clr or rst.
                end

                default: begin
                    w_state_next = S_SEED0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign match    = r_match;
    assign mismatch = r_mismatch;
    assign locked   = (r_state == S_TRACK);
    assign expected = locked ? w_sum : '0;
    assign term_cnt = r_term_cnt;

endmodule : fib_checker

// File: tb/tb_fib_checker.sv
// -----------------------------------------------------------------------------
// tb_fib_checker
// Directed bench for fib_checker. Two instances share clock and reset:
//   dut    : WIDTH=4, CNT_W=8, CHECK_SEED=0
//   dut_cs : WIDTH=4, CNT_W=2, CHECK_SEED=1 (small counter to reach saturation)
// Each step drives one cycle, queues the outputs expected after that edge and
// compares them one time unit after the edge.
// -----------------------------------------------------------------------------
module tb_fib_checker;

    logic       clk;
    logic       rst;

    logic       in_valid;
    logic [3:0] in_data;
    logic       clr;
    logic       match;
    logic       mismatch;
    logic       locked;
    logic [3:0] expected;
    logic [7:0] term_cnt;

    logic       cs_valid;
    logic [3:0] cs_data;
    logic       cs_clr;
    logic       cs_match;
    logic       cs_mismatch;
    logic       cs_locked;
    logic [3:0] cs_expected;
    logic [1:0] cs_term_cnt;

    fib_checker #(.WIDTH(4), .CNT_W(8), .CHECK_SEED(1'b0)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .clr      (clr),
        .match    (match),
        .mismatch (mismatch),
        .locked   (locked),
        .expected (expected),
        .term_cnt (term_cnt)
    );

    fib_checker #(.WIDTH(4), .CNT_W(2), .CHECK_SEED(1'b1)) dut_cs (
        .clk      (clk),
        .rst      (rst),
        .in_valid (cs_valid),
        .in_data  (cs_data),
        .clr      (cs_clr),
        .match    (cs_match),
        .mismatch (cs_mismatch),
        .locked   (cs_locked),
        .expected (cs_expected),
        .term_cnt (cs_term_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        bit         which;   // 0 = dut, 1 = dut_cs
        logic       m;
        logic       mm;
        logic       lk;
        logic [7:0] cnt;
        logic [3:0] ex;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   step_id = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_total++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            if (!e.which) begin
                chk($sformatf("s%0d_match", e.id),    32'(match),    32'(e.m));
                chk($sformatf("s%0d_mismatch", e.id), 32'(mismatch), 32'(e.mm));
                chk($sformatf("s%0d_locked", e.id),   32'(locked),   32'(e.lk));
                chk($sformatf("s%0d_term_cnt", e.id), 32'(term_cnt), 32'(e.cnt));
                chk($sformatf("s%0d_expected", e.id), 32'(expected), 32'(e.ex));
            end else begin
                chk($sformatf("cs%0d_match", e.id),    32'(cs_match),    32'(e.m));
                chk($sformatf("cs%0d_mismatch", e.id), 32'(cs_mismatch), 32'(e.mm));
                chk($sformatf("cs%0d_locked", e.id),   32'(cs_locked),   32'(e.lk));
                chk($sformatf("cs%0d_term_cnt", e.id), 32'(cs_term_cnt), 32'(e.cnt));
                chk($sformatf("cs%0d_expected", e.id), 32'(cs_expected), 32'(e.ex));
            end
            $display("step %0d dut%0d: checked match=%0b mismatch=%0b locked=%0b cnt=%0d exp=%0d",
                     e.id, e.which, e.m, e.mm, e.lk, e.cnt, e.ex);
        end
    endtask

    // One clock cycle: drive inputs, queue the expected post-edge outputs,
    // release inputs after the edge and compare.
    task automatic step(input bit which, input logic v, input logic c, input logic [3:0] d,
                        input logic em, input logic emm, input logic el,
                        input logic [7:0] ecnt, input logic [3:0] eex);
        exp_t e;
        if (!which) begin
            in_valid = v; clr = c; in_data = d;
        end else begin
            cs_valid = v; cs_clr = c; cs_data = d;
        end
        e.id = step_id; e.which = which; e.m = em; e.mm = emm; e.lk = el;
        e.cnt = ecnt; e.ex = eex;
        sb.push_back(e);
        step_id++;
        @(posedge clk);
        #1;
        in_valid = 1'b0; clr = 1'b0;
        cs_valid = 1'b0; cs_clr = 1'b0;
        check_out();
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; in_data = '0; clr = 1'b0;
        cs_valid = 1'b0; cs_data = '0; cs_clr = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_match",    32'(match),    32'd0);
        chk("rst_mismatch", 32'(mismatch), 32'd0);
        chk("rst_locked",   32'(locked),   32'd0);
        chk("rst_expected", 32'(expected), 32'd0);
        chk("rst_term_cnt", 32'(term_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Main sequence 0,1,1,2,3,5,8,13 back-to-back
        //        which v  c  d   m  mm lk cnt exp
        step(0, 1, 0, 0,  0, 0, 0, 0, 0);
        step(0, 1, 0, 1,  0, 0, 1, 0, 1);
        step(0, 1, 0, 1,  1, 0, 1, 1, 2);
        step(0, 1, 0, 2,  1, 0, 1, 2, 3);
        step(0, 1, 0, 3,  1, 0, 1, 3, 5);
        step(0, 1, 0, 5,  1, 0, 1, 4, 8);
        step(0, 1, 0, 8,  1, 0, 1, 5, 13);
        step(0, 1, 0, 13, 1, 0, 1, 6, 5);    // 8+13=21 wraps to 5

        // Idle gap: nothing moves, no pulses
        step(0, 0, 0, 4,  0, 0, 1, 6, 5);
        step(0, 0, 0, 4,  0, 0, 1, 6, 5);
        step(0, 0, 0, 4,  0, 0, 1, 6, 5);

        // Wrapped continuation 5,2,7
        step(0, 1, 0, 5,  1, 0, 1, 7, 2);
        step(0, 1, 0, 2,  1, 0, 1, 8, 7);
        step(0, 1, 0, 7,  1, 0, 1, 9, 9);

        // clr together with a would-be matching term: term dropped
        step(0, 1, 1, 9,  0, 0, 0, 0, 0);

        // 0,1,1,3 -> mismatch on 3, then 4,7
        step(0, 1, 0, 0,  0, 0, 0, 0, 0);
        step(0, 1, 0, 1,  0, 0, 1, 0, 1);
        step(0, 1, 0, 1,  1, 0, 1, 1, 2);
        step(0, 1, 0, 3,  0, 1, 0, 0, 0);
`ifdef FIB_CHECKER_RESYNC_EN
        step(0, 1, 0, 4,  0, 0, 1, 0, 7);    // 3,4 reseed
        step(0, 1, 0, 7,  1, 0, 1, 1, 11);
`else
        step(0, 1, 0, 4,  0, 0, 0, 0, 0);    // fault: ignored
        step(0, 1, 0, 7,  0, 0, 0, 0, 0);
`endif
        step(0, 0, 1, 0,  0, 0, 0, 0, 0);    // clr alone
        step(0, 1, 0, 0,  0, 0, 0, 0, 0);
        step(0, 1, 0, 1,  0, 0, 1, 0, 1);
        step(0, 1, 0, 1,  1, 0, 1, 1, 2);

        // Asynchronous reset between edges while tracking
        @(negedge clk);
        #2;
        chk("pre_arst_locked", 32'(locked), 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_match",    32'(match),    32'd0);
        chk("arst_mismatch", 32'(mismatch), 32'd0);
        chk("arst_locked",   32'(locked),   32'd0);
        chk("arst_expected", 32'(expected), 32'd0);
        chk("arst_term_cnt", 32'(term_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(0, 1, 0, 0,  0, 0, 0, 0, 0);
        step(0, 1, 0, 1,  0, 0, 1, 0, 1);
        step(0, 1, 0, 1,  1, 0, 1, 1, 2);

        // CHECK_SEED=1 instance (CNT_W=2)
        step(1, 1, 0, 2,  0, 1, 0, 0, 0);    // bad seed0: stay
        step(1, 1, 0, 0,  0, 0, 0, 0, 0);
        step(1, 1, 0, 5,  0, 1, 0, 0, 0);    // bad seed1: back to seed0
        step(1, 1, 0, 0,  0, 0, 0, 0, 0);
        step(1, 1, 0, 1,  0, 0, 1, 0, 1);
        step(1, 1, 0, 1,  1, 0, 1, 1, 2);
        step(1, 1, 0, 2,  1, 0, 1, 2, 3);
        step(1, 1, 0, 3,  1, 0, 1, 3, 5);
        step(1, 1, 0, 5,  1, 0, 1, 3, 8);    // counter saturates at 3

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_fib_checker
